centroid_moment_acc: RTL and testbench
======================================

Name: centroid_moment_acc

Overview:
- Upstream feeder of the eye-tracker centroid divider control. Accumulates first-order moments of dark (pupil) pixels over one video frame: sum of x, sum of y, and pixel count.
- At each frame boundary it snapshots the totals. It then presents two division jobs (sum_x/count, then sum_y/count) on the divider's dividend and divisor stream channels.
- Accumulation of the next frame continues while the jobs drain.

Parameters:
- X_W, 10, width of the horizontal pixel coordinate; max line length 2^X_W.
- Y_W, 10, width of the vertical line coordinate; max frame height 2^Y_W.
- PIX_W, 8, pixel luminance width.
- Derived localparams, not overridable:
  - CNT_W = X_W+Y_W+1
  - SUM_W = CNT_W+max(X_W,Y_W)

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- iVSYNC  in  1  frame sync, high during vertical blanking; rising edge = frame boundary.
- iDE  in  1  pixel data enable, one pixel per cycle while high.
- iPIX  in  PIX_W  pixel luminance.
- iTHRESH  in  PIX_W  dark threshold; pixel qualifies when iPIX <= iTHRESH.
- oDIVIDEND_TDATA  out  SUM_W  moment sum for the current job.
- oDIVIDEND_TVALID  out  1  dividend channel valid.
- iDIVIDEND_TREADY  in  1  dividend channel ready.
- oDIVISOR_TDATA  out  CNT_W  qualified pixel count.
- oDIVISOR_TVALID  out  1  divisor channel valid.
- iDIVISOR_TREADY  in  1  divisor channel ready.
- oJOB_AXIS  out  1  0 = x job, 1 = y job; stable while either TVALID is high.
- oNO_BLOB  out  1  one-cycle pulse: frame ended with count 0, no jobs issued.
- oOVERRUN  out  1  one-cycle pulse: frame ended while the previous jobs were still pending.

Behaviour:
- Reset:
  - All outputs 0, state IDLE.
  - Coordinate counters, accumulators and snapshot registers 0.
- Coordinates:
  - x_cnt increments each cycle with iDE & ~iVSYNC.
  - x_cnt clears to 0 on the iDE falling edge, and y_cnt increments then.
  - Both clear on the iVSYNC rising edge.
  - x_cnt saturates at 2^X_W-1 and y_cnt at 2^Y_W-1.
  - A pixel arriving while its coordinate counter is saturated is not qualified.
- Qualification: the cycle's pixel qualifies when iDE=1, iVSYNC=0, iPIX<=iTHRESH and no coordinate is saturated. A qualifying pixel adds:
  - x_cnt into acc_x
  - y_cnt into acc_y
  - 1 into acc_n
- Coordinate of a pixel: the value of x_cnt/y_cnt in the same cycle as the pixel. The first pixel of a line is x=0; the first line is y=0.
- Overflow: accumulators cannot overflow by construction and need no saturation.
- Frame boundary: iVSYNC sampled 1 with previous sample 0 at cycle N (edge detector on registered iVSYNC). At cycle N:
  - acc_x, acc_y, acc_n are cleared.
  - Their pre-clear values are copied into the snapshot registers, but only when state is IDLE.
  - Any qualifying pixel in cycle N is ignored (iVSYNC=1).
- State machine {IDLE, SEND_X, SEND_Y}:
  - IDLE, boundary, acc_n!=0: load snapshot, go to SEND_X. At N+1 both TVALIDs = 1 and oJOB_AXIS = 0.
  - IDLE, boundary, acc_n==0: oNO_BLOB = 1 at N+1; stay IDLE.
  - SEND_X: dividend = snap_x, divisor = snap_n.
    - Each channel's TVALID drops independently the cycle after its own TVALID&TREADY handshake.
    - When both channels have completed (same cycle or different cycles): next cycle state is SEND_Y, both TVALIDs = 1, oJOB_AXIS = 1.
  - SEND_Y: same rules with dividend = snap_y. When both channels complete, go to IDLE.
  - Minimum 1 cycle of TVALID per job; back-to-back with always-ready sinks: SEND_X 1 cycle, SEND_Y 1 cycle.
- Boundary while in SEND_X or SEND_Y:
  - The new totals are discarded.
  - Accumulators still clear.
  - oOVERRUN pulses at N+1.
  - The jobs in flight are unaffected.
- AXIS rules: TDATA and oJOB_AXIS are stable while TVALID is high. TVALID never depends combinationally on TREADY.
- Reset mid-job: all state is lost immediately; TVALIDs drop asynchronously.

Decomposition:
- Shared package/include holds:
  - the state encoding localparams (IDLE=2'd0, SEND_X=2'd1, SEND_Y=2'd2)
  - the CNT_W/SUM_W derivation functions
- One natural sub-module: sync_edge_det, a registered rise/fall detector, used for both iVSYNC and iDE. Uses an active-high asynchronous reset, unlike the existing active-low edge detector.

Test Plan:
- Single dark pixel at (x=3, y=2), iTHRESH=40, iPIX=10, then iVSYNC rise -> X job (dividend=3, divisor=1), then Y job (dividend=2, divisor=1), oJOB_AXIS 0 then 1.
- 2x2 dark block at x=4..5, y=6..7 in an 8x8 frame with ready tied high -> X job dividend=18, divisor=4; Y job dividend=26, divisor=4; each TVALID high exactly 1 cycle.
- All pixels 200 with iTHRESH=40 -> oNO_BLOB single-cycle pulse, no TVALID, state stays IDLE.
- Dividend ready at cycle 0 and divisor ready 5 cycles later -> oDIVIDEND_TVALID drops after 1 cycle, oDIVISOR_TVALID holds 6 cycles, SEND_Y starts only after the divisor handshake.
- Hold both TREADY=0 across the next iVSYNC rise -> oOVERRUN pulses. Original snapshot values are still delivered, and the following frame is accumulated from zero.
- Assert RST during SEND_X -> TVALIDs 0 immediately; after release a fresh frame with one pixel at (1,1) yields jobs 1/1 and 1/1.

Source files
------------

// File: rtl/centroid_moment_acc_pkg.sv
// Shared types and width helpers for the centroid moment accumulator.
package centroid_moment_acc_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEND_X = 2'd1,
      SEND_Y = 2'd2
   } state_e;

   // Pixel count needs one bit more than the frame area to hold 2^(X_W+Y_W).
   function automatic int unsigned cnt_width(input int unsigned xw, input int unsigned yw);
      return xw + yw + 1;
   endfunction

   function automatic int unsigned sum_width(input int unsigned xw, input int unsigned yw);
      return cnt_width(xw, yw) + ((xw > yw) ? xw : yw);
   endfunction

endpackage

// File: rtl/centroid_moment_acc_sync_edge_det.sv
// Registered rise/fall detector: edges are flagged in the cycle the new level is sampled.
module sync_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic rise_o,
   output logic fall_o
);

   logic d_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         d_q <= 1'b0;
      end else begin
         d_q <= d_i;
      end
   end

   assign rise_o = d_i & ~d_q;
   assign fall_o = ~d_i & d_q;

endmodule

// File: rtl/centroid_moment_acc.sv
// Accumulates dark-pixel moments per frame and streams sum_x/count, sum_y/count jobs
// to the centroid divider while the next frame keeps accumulating.
module centroid_moment_acc
   import centroid_moment_acc_pkg::*;
#(
   parameter  int unsigned X_W   = 10,
   parameter  int unsigned Y_W   = 10,
   parameter  int unsigned PIX_W = 8,
   localparam int unsigned CNT_W = cnt_width(X_W, Y_W),
   localparam int unsigned SUM_W = sum_width(X_W, Y_W)
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             iVSYNC,
   input  logic             iDE,
   input  logic [PIX_W-1:0] iPIX,
   input  logic [PIX_W-1:0] iTHRESH,
   output logic [SUM_W-1:0] oDIVIDEND_TDATA,
   output logic             oDIVIDEND_TVALID,
   input  logic             iDIVIDEND_TREADY,
   output logic [CNT_W-1:0] oDIVISOR_TDATA,
   output logic             oDIVISOR_TVALID,
   input  logic             iDIVISOR_TREADY,
   output logic             oJOB_AXIS,
   output logic             oNO_BLOB,
   output logic             oOVERRUN
);

   localparam logic [X_W-1:0] X_MAX = '1;
   localparam logic [Y_W-1:0] Y_MAX = '1;

   logic vs_rise, vs_fall_unused, de_rise_unused, de_fall;

   sync_edge_det u_vs_edge (
      .clk    (CLK),
      .rst    (RST),
      .d_i    (iVSYNC),
      .rise_o (vs_rise),
      .fall_o (vs_fall_unused)
   );

   sync_edge_det u_de_edge (
      .clk    (CLK),
      .rst    (RST),
      .d_i    (iDE),
      .rise_o (de_rise_unused),
      .fall_o (de_fall)
   );

   logic [X_W-1:0]   x_q, x_d;
   logic [Y_W-1:0]   y_q, y_d;
   logic [SUM_W-1:0] acc_x_q, acc_x_d, acc_y_q, acc_y_d;
   logic [CNT_W-1:0] acc_n_q, acc_n_d;
   logic             x_sat, y_sat, pix_ok;

   assign x_sat  = (x_q == X_MAX);
   assign y_sat  = (y_q == Y_MAX);
   assign pix_ok = iDE & ~iVSYNC & (iPIX <= iTHRESH) & ~x_sat & ~y_sat;

   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (vs_rise) begin
         x_d = '0;
         y_d = '0;
      end else if (de_fall) begin
         x_d = '0;
         if (!y_sat) y_d = y_q + Y_W'(1);
      end else if (iDE && !iVSYNC && !x_sat) begin
         x_d = x_q + X_W'(1);
      end
   end

   always_comb begin
      acc_x_d = acc_x_q;
      acc_y_d = acc_y_q;
      acc_n_d = acc_n_q;
      if (vs_rise) begin
         acc_x_d = '0;
         acc_y_d = '0;
         acc_n_d = '0;
      end else if (pix_ok) begin
         acc_x_d = acc_x_q + SUM_W'(x_q);
         acc_y_d = acc_y_q + SUM_W'(y_q);
         acc_n_d = acc_n_q + CNT_W'(1);
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         x_q     <= '0;
         y_q     <= '0;
         acc_x_q <= '0;
         acc_y_q <= '0;
         acc_n_q <= '0;
      end else begin
         x_q     <= x_d;
         y_q     <= y_d;
         acc_x_q <= acc_x_d;
         acc_y_q <= acc_y_d;
         acc_n_q <= acc_n_d;
      end
   end

   state_e           state_q;
   logic [SUM_W-1:0] snap_x_q, snap_y_q;
   logic [CNT_W-1:0] snap_n_q;
   logic             dvd_vld_q, dvs_vld_q, job_q, no_blob_q, overrun_q;
   logic             both_done;

   // A channel counts as done if it already handshook earlier or is handshaking now.
   assign both_done = (~dvd_vld_q | iDIVIDEND_TREADY) & (~dvs_vld_q | iDIVISOR_TREADY);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q   <= IDLE;
         snap_x_q  <= '0;
         snap_y_q  <= '0;
         snap_n_q  <= '0;
         dvd_vld_q <= 1'b0;
         dvs_vld_q <= 1'b0;
         job_q     <= 1'b0;
         no_blob_q <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         no_blob_q <= 1'b0;
         overrun_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (vs_rise) begin
                  if (acc_n_q != '0) begin
                     snap_x_q  <= acc_x_q;
                     snap_y_q  <= acc_y_q;
                     snap_n_q  <= acc_n_q;
                     dvd_vld_q <= 1'b1;
                     dvs_vld_q <= 1'b1;
                     job_q     <= 1'b0;
                     state_q   <= SEND_X;
                  end else begin
                     no_blob_q <= 1'b1;
                  end
               end
            end
            SEND_X, SEND_Y: begin
               if (vs_rise) overrun_q <= 1'b1;
               if (both_done) begin
                  if (state_q == SEND_X) begin
                     dvd_vld_q <= 1'b1;
                     dvs_vld_q <= 1'b1;
                     job_q     <= 1'b1;
                     state_q   <= SEND_Y;
                  end else begin
                     dvd_vld_q <= 1'b0;
                     dvs_vld_q <= 1'b0;
                     job_q     <= 1'b0;
                     state_q   <= IDLE;
                  end
               end else begin
                  if (dvd_vld_q && iDIVIDEND_TREADY) dvd_vld_q <= 1'b0;
                  if (dvs_vld_q && iDIVISOR_TREADY)  dvs_vld_q <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign oDIVIDEND_TDATA  = job_q ? snap_y_q : snap_x_q;
   assign oDIVIDEND_TVALID = dvd_vld_q;
   assign oDIVISOR_TDATA   = snap_n_q;
   assign oDIVISOR_TVALID  = dvs_vld_q;
   assign oJOB_AXIS        = job_q;
   assign oNO_BLOB         = no_blob_q;
   assign oOVERRUN         = overrun_q;

endmodule

// File: tb/tb_centroid_moment_acc.sv
// Bench for centroid_moment_acc: frame-level reference model plus directed literal checks.
module tb_centroid_moment_acc;

   localparam int SUM_W = 31;
   localparam int CNT_W = 21;

   logic             CLK = 1'b0;
   logic             RST;
   logic             iVSYNC, iDE;
   logic [7:0]       iPIX, iTHRESH;
   logic [SUM_W-1:0] oDIVIDEND_TDATA;
   logic             oDIVIDEND_TVALID, iDIVIDEND_TREADY;
   logic [CNT_W-1:0] oDIVISOR_TDATA;
   logic             oDIVISOR_TVALID, iDIVISOR_TREADY;
   logic             oJOB_AXIS, oNO_BLOB, oOVERRUN;

   centroid_moment_acc #(.X_W(10), .Y_W(10), .PIX_W(8)) dut (
      .CLK              (CLK),
      .RST              (RST),
      .iVSYNC           (iVSYNC),
      .iDE              (iDE),
      .iPIX             (iPIX),
      .iTHRESH          (iTHRESH),
      .oDIVIDEND_TDATA  (oDIVIDEND_TDATA),
      .oDIVIDEND_TVALID (oDIVIDEND_TVALID),
      .iDIVIDEND_TREADY (iDIVIDEND_TREADY),
      .oDIVISOR_TDATA   (oDIVISOR_TDATA),
      .oDIVISOR_TVALID  (oDIVISOR_TVALID),
      .iDIVISOR_TREADY  (iDIVISOR_TREADY),
      .oJOB_AXIS        (oJOB_AXIS),
      .oNO_BLOB         (oNO_BLOB),
      .oOVERRUN         (oOVERRUN)
   );

   always #5 CLK = ~CLK;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Stimulus state: the generator publishes the true coordinate of each pixel it drives.
   int  cur_x, cur_y;
   bit  dark_map [16][16];
   int  dark_val   = -1;
   int  bright_val = -1;
   bit  rdy_rand   = 0;

   // Reference model: whole-frame moments and a queue of jobs awaiting delivery.
   typedef struct {
      longint dvd;
      longint dvs;
      bit     axis;
   } job_t;

   job_t   jq[$];
   longint m_sx, m_sy, m_n;
   bit     dvd_done, dvs_done, vs_prev, exp_nb, exp_ov;
   longint dvd_log[$], dvs_log[$];
   bit     ax_log[$];
   int     vcnt_dvd, vcnt_dvs, nb_cnt, ov_cnt;

   always @(negedge CLK) begin
      if (RST) begin
         jq.delete();
         m_sx = 0; m_sy = 0; m_n = 0;
         dvd_done = 0; dvs_done = 0; vs_prev = 0; exp_nb = 0; exp_ov = 0;
         chk("rst_dvd_valid", oDIVIDEND_TVALID, 0);
         chk("rst_dvs_valid", oDIVISOR_TVALID, 0);
      end else begin
         bit bnd, push_jobs;
         longint sx, sy, sn;
         chk("no_blob", oNO_BLOB, exp_nb);
         chk("overrun", oOVERRUN, exp_ov);
         if (oDIVIDEND_TVALID) vcnt_dvd++;
         if (oDIVISOR_TVALID)  vcnt_dvs++;
         if (oNO_BLOB) nb_cnt++;
         if (oOVERRUN) ov_cnt++;
         if (jq.size() > 0) begin
            chk("dvd_valid", oDIVIDEND_TVALID, !dvd_done);
            chk("dvs_valid", oDIVISOR_TVALID, !dvs_done);
            chk("job_axis", oJOB_AXIS, jq[0].axis);
            if (!dvd_done) chk("dividend", oDIVIDEND_TDATA, jq[0].dvd);
            if (!dvs_done) chk("divisor", oDIVISOR_TDATA, jq[0].dvs);
         end else begin
            chk("idle_dvd_valid", oDIVIDEND_TVALID, 0);
            chk("idle_dvs_valid", oDIVISOR_TVALID, 0);
         end

         // Frame boundary decision sees the job queue as it stood before this edge.
         bnd = iVSYNC && !vs_prev;
         vs_prev = iVSYNC;
         exp_nb = 0; exp_ov = 0; push_jobs = 0;
         sx = m_sx; sy = m_sy; sn = m_n;
         if (bnd) begin
            if (jq.size() > 0) exp_ov = 1;
            else if (m_n == 0) exp_nb = 1;
            else push_jobs = 1;
            m_sx = 0; m_sy = 0; m_n = 0;
         end else if (iDE && !iVSYNC && iPIX <= iTHRESH) begin
            m_sx += cur_x; m_sy += cur_y; m_n++;
         end

         if (jq.size() > 0) begin
            if (!dvd_done && iDIVIDEND_TREADY) begin
               dvd_done = 1; dvd_log.push_back(longint'(oDIVIDEND_TDATA)); ax_log.push_back(oJOB_AXIS);
            end
            if (!dvs_done && iDIVISOR_TREADY) begin
               dvs_done = 1; dvs_log.push_back(longint'(oDIVISOR_TDATA));
            end
            if (dvd_done && dvs_done) begin
               void'(jq.pop_front());
               dvd_done = 0; dvs_done = 0;
            end
         end
         if (push_jobs) begin
            jq.push_back('{dvd: sx, dvs: sn, axis: 1'b0});
            jq.push_back('{dvd: sy, dvs: sn, axis: 1'b1});
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
      if (rdy_rand) begin
         iDIVIDEND_TREADY = 1'($urandom_range(0, 1));
         iDIVISOR_TREADY  = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic clear_map();
      for (int r = 0; r < 16; r++)
         for (int c = 0; c < 16; c++) dark_map[r][c] = 0;
   endtask

   task automatic clear_logs();
      dvd_log.delete(); dvs_log.delete(); ax_log.delete();
      vcnt_dvd = 0; vcnt_dvs = 0; nb_cnt = 0; ov_cnt = 0;
   endtask

   task automatic run_frame(input int w, input int h, input int thr, input int gap, input int vbl);
      iTHRESH = 8'(thr);
      for (int r = 0; r < h; r++) begin
         for (int c = 0; c < w; c++) begin
            iDE = 1; cur_x = c; cur_y = r;
            if (dark_map[r][c])
               iPIX = (dark_val >= 0) ? 8'(dark_val) : 8'($urandom_range(0, thr));
            else
               iPIX = (bright_val >= 0) ? 8'(bright_val) : 8'($urandom_range(thr + 1, 255));
            tick();
         end
         iDE = 0; iPIX = '0;
         repeat (gap) tick();
      end
      tick();
      iVSYNC = 1;
      repeat (vbl) tick();
      iVSYNC = 0;
      tick();
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while ((jq.size() != 0 || oDIVIDEND_TVALID || oDIVISOR_TVALID) && n < 400) begin
         tick();
         n++;
      end
      chk({"drain_timeout_", tag}, (n < 400), 1);
      repeat (2) tick();
   endtask

   task automatic check_jobs(input string tag, input longint x, input longint y, input longint n);
      chk({tag, "_dvd_count"}, dvd_log.size(), 2);
      chk({tag, "_dvs_count"}, dvs_log.size(), 2);
      if (dvd_log.size() == 2 && dvs_log.size() == 2 && ax_log.size() == 2) begin
         chk({tag, "_x_dividend"}, dvd_log[0], x);
         chk({tag, "_y_dividend"}, dvd_log[1], y);
         chk({tag, "_x_divisor"}, dvs_log[0], n);
         chk({tag, "_y_divisor"}, dvs_log[1], n);
         chk({tag, "_axis0"}, ax_log[0], 0);
         chk({tag, "_axis1"}, ax_log[1], 1);
      end
   endtask

   task automatic set_ready(input logic a, input logic b);
      iDIVIDEND_TREADY = a;
      iDIVISOR_TREADY  = b;
   endtask

   initial begin
      int wv;
      RST = 1; iVSYNC = 0; iDE = 0; iPIX = '0; iTHRESH = 8'd40;
      cur_x = 0; cur_y = 0;
      set_ready(1, 1);
      clear_map();
      clear_logs();
      repeat (3) tick();
      chk("reset_dividend", oDIVIDEND_TDATA, 0);
      chk("reset_divisor", oDIVISOR_TDATA, 0);
      chk("reset_axis", oJOB_AXIS, 0);
      chk("reset_no_blob", oNO_BLOB, 0);
      chk("reset_overrun", oOVERRUN, 0);
      RST = 0;
      tick();

      // Single dark pixel at (3,2).
      clear_logs(); clear_map(); dark_map[2][3] = 1; dark_val = 10; bright_val = 200;
      run_frame(6, 4, 40, 2, 3);
      wait_idle("single");
      check_jobs("single", 3, 2, 1);

      // 2x2 block at x=4..5, y=6..7; dark pixels sit exactly on the threshold.
      clear_logs(); clear_map();
      dark_map[6][4] = 1; dark_map[6][5] = 1; dark_map[7][4] = 1; dark_map[7][5] = 1;
      dark_val = 40; bright_val = 41;
      run_frame(8, 8, 40, 1, 2);
      wait_idle("block");
      check_jobs("block", 18, 26, 4);
      chk("block_dvd_valid_cycles", vcnt_dvd, 2);
      chk("block_dvs_valid_cycles", vcnt_dvs, 2);

      // All pixels bright.
      clear_logs(); clear_map(); bright_val = 200;
      run_frame(8, 8, 40, 1, 3);
      wait_idle("noblob");
      chk("noblob_pulses", nb_cnt, 1);
      chk("noblob_dvd_valid_cycles", vcnt_dvd, 0);
      chk("noblob_dvs_valid_cycles", vcnt_dvs, 0);

      // Divisor sink five cycles slower than the dividend sink.
      set_ready(0, 0);
      clear_logs(); clear_map(); dark_map[1][2] = 1; dark_val = 10;
      run_frame(5, 3, 40, 1, 2);
      wv = 0;
      while (!oDIVIDEND_TVALID && wv < 50) begin tick(); wv++; end
      chk("skew_valid_seen", oDIVIDEND_TVALID, 1);
      vcnt_dvd = 0; vcnt_dvs = 0;
      set_ready(1, 0);
      repeat (5) tick();
      chk("skew_axis_before_dvs", oJOB_AXIS, 0);
      chk("skew_dvd_dropped", oDIVIDEND_TVALID, 0);
      chk("skew_dvs_held", oDIVISOR_TVALID, 1);
      set_ready(1, 1);
      wait_idle("skew");
      check_jobs("skew", 2, 1, 1);
      chk("skew_dvd_valid_cycles", vcnt_dvd, 2);
      chk("skew_dvs_valid_cycles", vcnt_dvs, 7);

      // Stalled sinks across the next frame boundary.
      set_ready(0, 0);
      clear_logs(); clear_map(); dark_map[1][5] = 1;
      run_frame(7, 3, 40, 1, 2);
      clear_map(); dark_map[0][1] = 1; dark_map[2][3] = 1; dark_map[3][6] = 1;
      run_frame(7, 4, 40, 1, 2);
      chk("overrun_pulses", ov_cnt, 1);
      set_ready(1, 1);
      wait_idle("overrun");
      check_jobs("overrun", 5, 1, 1);
      clear_logs(); clear_map(); dark_map[3][2] = 1;
      run_frame(5, 4, 40, 1, 2);
      wait_idle("after_overrun");
      check_jobs("after_overrun", 2, 3, 1);

      // Reset while the X job is pending.
      set_ready(0, 0);
      clear_logs(); clear_map(); dark_map[2][2] = 1;
      run_frame(5, 4, 40, 1, 2);
      chk("pre_reset_valid", oDIVIDEND_TVALID, 1);
      #2 RST = 1;
      #1;
      chk("async_rst_dvd_valid", oDIVIDEND_TVALID, 0);
      chk("async_rst_dvs_valid", oDIVISOR_TVALID, 0);
      iDE = 0; iVSYNC = 0;
      repeat (2) tick();
      RST = 0;
      tick();
      set_ready(1, 1);
      clear_logs(); clear_map(); dark_map[1][1] = 1;
      run_frame(4, 3, 40, 1, 2);
      wait_idle("post_reset");
      check_jobs("post_reset", 1, 1, 1);

      // Randomised frames with random sink back-pressure.
      dark_val = -1; bright_val = -1;
      rdy_rand = 1;
      for (int f = 0; f < 14; f++) begin
         int w, h, thr, dens;
         w = $urandom_range(2, 12);
         h = $urandom_range(1, 8);
         thr = $urandom_range(1, 200);
         dens = $urandom_range(0, 3);
         clear_map();
         for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++)
               dark_map[r][c] = ($urandom_range(0, 3) < dens);
         run_frame(w, h, thr, $urandom_range(1, 3), $urandom_range(2, 5));
         if ($urandom_range(0, 1) == 1) repeat ($urandom_range(0, 6)) tick();
      end
      rdy_rand = 0;
      set_ready(1, 1);
      wait_idle("random");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got %0d expected %0d", 1, 0);
      $fatal(1, "timeout");
   end

endmodule
